fixed_encoder_lpc: RTL and testbench
====================================

Name: fixed_encoder_lpc

Overview:
- FLAC fixed-predictor encoder; the inverse of the fixed-predictor decoder.
- Takes a block of signed PCM samples and a predictor order (0-4).
- Emits the first `order` samples verbatim as warm-up. Every following sample is emitted as residual = sample - prediction.
- Also accumulates the sum of |residual| over the block, so the frame builder can compare orders and pick one.

Parameters:
- DATA_W, 16, sample width (signed)
- RES_W, DATA_W+4, residual width (signed). Order-4 worst case is ±8*(2^DATA_W - 1), which fits.
- SUM_W, 32, width of the block |residual| accumulator (unsigned, saturating)

Ports:
- iClk  in  1  clock
- iRst  in  1  synchronous active-high reset
- iStart  in  1  one-cycle pulse: start a new block, latch iOrder, clear history and accumulator
- iOrder  in  3  predictor order; sampled only when iStart=1
- iEnable  in  1  iSample valid this cycle
- iSample  in  DATA_W  signed input sample
- iLast  in  1  qualifies iEnable: this is the final sample of the block
- oData  out  RES_W  signed warm-up sample (sign-extended) or residual
- oValid  out  1  oData valid
- oWarmup  out  1  current oData is a verbatim warm-up sample
- oAbsSum  out  SUM_W  sum of |residual| over non-warm-up outputs of the block
- oDone  out  1  one-cycle pulse; oAbsSum is final
- oOrderErr  out  1  latched iOrder was >4; block is encoded as order 0

Behaviour:
- Reset (iRst=1 at a clock edge):
  - all outputs become 0;
  - history x1..x4 = 0, order = 0;
  - state = IDLE;
  - any block in progress is abandoned with no oDone.
- States:
  - IDLE → WARMUP on iStart (order>0).
  - IDLE → RUN on iStart (order=0).
  - WARMUP → RUN when the warm-up count reaches order.
  - RUN → IDLE after an accepted sample with iLast=1.
  - iStart in any state restarts the block (also clears the warm-up counter, history and accumulator). If iEnable is also high that cycle, the sample is the block's first sample.
- In IDLE, iEnable is ignored (oValid stays 0).
- Sample acceptance: a sample is accepted when iEnable=1 in WARMUP or RUN (or together with iStart). iEnable=0 cycles hold all state; gaps are allowed.
- Latency: an accepted sample at edge N produces oValid=1 and oData at edge N+1. oValid is 0 otherwise; oData holds its last value.
- WARMUP:
  - oData = sign-extended iSample, oWarmup=1.
  - The sample is shifted into history (x4←x3←x2←x1←iSample).
  - The warm-up counter increments.
- RUN prediction, computed in RES_W arithmetic with no overflow possible:
  - order 0: p = 0
  - order 1: p = x1
  - order 2: p = 2x1 - x2
  - order 3: p = 3x1 - 3x2 + x3
  - order 4: p = 4x1 - 6x2 + 4x3 - x4
  - oData = iSample - p, oWarmup=0.
  - The sample is shifted into history.
  - oAbsSum += |oData|, saturating at 2^SUM_W - 1.
- Block end: iLast=1 on an accepted sample gives oDone=1 on the same edge as that sample's oValid. oAbsSum then holds until the next iStart or reset.
- Short block: iLast during WARMUP ends the block. oDone=1, oAbsSum=0, and the FSM returns to IDLE.
- Order error: iOrder 5-7 at iStart sets oOrderErr=1 until the next iStart or reset, and the block is encoded as order 0.
- Invariant: feeding oData through the fixed decoder with the same order reproduces iSample bit-exactly.

Test Plan:
- Order 3, samples 20,10,-7,-4,8 (iLast on 8):
  - oData = 20,10,-7 (oWarmup=1), then 27,-11 (oWarmup=0);
  - oAbsSum = 38 with oDone on the 5th oValid.
- Order 1 on 10,-7,-4 gives oData 10,-17,3. Order 2 on 10,-7,-4,8 gives 10,-7,20,9 with oAbsSum=29. Order 0 on 10,-7 passes through unchanged, oWarmup=0.
- Order 4 extreme: samples 32767,-32768,32767,-32768,32767 → 5th oData = +524280, with no wrap. The negated sequence gives -524280.
- Gaps and restart:
  - order 2 on 5,6,7 with iEnable low for 3 cycles between samples → oData 5,6,0 (identical to the no-gap run);
  - iStart mid-RUN with order 1 → next sample is emitted as warm-up, and oAbsSum is cleared.
- Edge cases:
  - iRst asserted mid-block → all outputs 0 next cycle, no oDone;
  - iOrder=6 → oOrderErr=1 and verbatim residuals;
  - iLast on 2nd sample of an order-3 block → oDone, oAbsSum=0.

Source files
------------

// File: rtl/fixed_encoder_lpc.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fixed_encoder_lpc: FLAC fixed-predictor encoder (warm-up + residuals)  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module fixed_encoder_lpc #(
  parameter int DATA_W = 16,
  parameter int RES_W  = DATA_W + 4,
  parameter int SUM_W  = 32
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iStart,
  input  logic [2:0]              iOrder,
  input  logic                    iEnable,
  input  logic signed [DATA_W-1:0] iSample,
  input  logic                    iLast,
  output logic signed [RES_W-1:0] oData,
  output logic                    oValid,
  output logic                    oWarmup,
  output logic [SUM_W-1:0]        oAbsSum,
  output logic                    oDone,
  output logic                    oOrderErr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t                    r_state;
  logic [2:0]                r_order;
  logic [2:0]                r_cnt;
  logic signed [DATA_W-1:0]  r_x1, r_x2, r_x3, r_x4;

  function automatic logic signed [RES_W-1:0] sext(input logic signed [DATA_W-1:0] v);
    return {{(RES_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // A start pulse takes effect in the same cycle, so the block's first sample
  // may arrive alongside it and must see the fresh (cleared) context.
  logic [2:0]               w_start_order;
  logic [2:0]               w_order;
  state_t                   w_state;
  logic [2:0]               w_cnt;
  logic signed [DATA_W-1:0] w_h1, w_h2, w_h3, w_h4;
  logic [SUM_W-1:0]         w_sum;
  logic                     w_accept;
  logic                     w_in_warm;

  assign w_start_order = (iOrder > 3'd4) ? 3'd0 : iOrder;
  assign w_order   = iStart ? w_start_order : r_order;
  assign w_state   = iStart ? ((w_start_order == 3'd0) ? S_RUN : S_WARMUP) : r_state;
  assign w_cnt     = iStart ? 3'd0 : r_cnt;
  assign w_h1      = iStart ? '0 : r_x1;
  assign w_h2      = iStart ? '0 : r_x2;
  assign w_h3      = iStart ? '0 : r_x3;
  assign w_h4      = iStart ? '0 : r_x4;
  assign w_sum     = iStart ? '0 : oAbsSum;
  assign w_accept  = iEnable && (w_state != S_IDLE);
  assign w_in_warm = (w_state == S_WARMUP);

  logic signed [RES_W-1:0] w_e1, w_e2, w_e3, w_e4;
  logic signed [RES_W-1:0] w_pred;
  logic signed [RES_W-1:0] w_res;
  logic [RES_W-1:0]        w_abs;
  logic [SUM_W:0]          w_sum_wide;
  logic [SUM_W-1:0]        w_sum_next;

  assign w_e1 = sext(w_h1);
  assign w_e2 = sext(w_h2);
  assign w_e3 = sext(w_h3);
  assign w_e4 = sext(w_h4);

  // Worst-case order-4 magnitude stays inside RES_W, so no saturation is needed.
  always_comb begin
    w_pred = '0;
    case (w_order)
      3'd1:    w_pred = w_e1;
      3'd2:    w_pred = (w_e1 <<< 1) - w_e2;
      3'd3:    w_pred = (w_e1 <<< 1) + w_e1 - (w_e2 <<< 1) - w_e2 + w_e3;
      3'd4:    w_pred = (w_e1 <<< 2) - (w_e2 <<< 2) - (w_e2 <<< 1) + (w_e3 <<< 2) - w_e4;
      default: w_pred = '0;
    endcase
  end

  assign w_res      = sext(iSample) - w_pred;
  assign w_abs      = w_res[RES_W-1] ? RES_W'(-w_res) : RES_W'(w_res);
  assign w_sum_wide = {1'b0, w_sum} + {{(SUM_W+1-RES_W){1'b0}}, w_abs};
  assign w_sum_next = w_sum_wide[SUM_W] ? {SUM_W{1'b1}} : w_sum_wide[SUM_W-1:0];

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state   <= S_IDLE;
      r_order   <= 3'd0;
      r_cnt     <= 3'd0;
      r_x1      <= '0;
      r_x2      <= '0;
      r_x3      <= '0;
      r_x4      <= '0;
      oData     <= '0;
      oValid    <= 1'b0;
      oWarmup   <= 1'b0;
      oAbsSum   <= '0;
      oDone     <= 1'b0;
      oOrderErr <= 1'b0;
    end else begin
      oValid <= 1'b0;
      oDone  <= 1'b0;
      if (iStart) begin
        r_order   <= w_start_order;
        oOrderErr <= (iOrder > 3'd4);
        r_state   <= w_state;
        r_cnt     <= 3'd0;
        r_x1      <= '0;
        r_x2      <= '0;
        r_x3      <= '0;
        r_x4      <= '0;
        oAbsSum   <= '0;
      end
      if (w_accept) begin
        oValid  <= 1'b1;
        oWarmup <= w_in_warm;
        oData   <= w_in_warm ? sext(iSample) : w_res;
        r_x4    <= w_h3;
        r_x3    <= w_h2;
        r_x2    <= w_h1;
        r_x1    <= iSample;
        if (w_in_warm) begin
          r_cnt <= 3'(w_cnt + 3'd1);
          if (3'(w_cnt + 3'd1) == w_order)
            r_state <= S_RUN;
        end else begin
          oAbsSum <= w_sum_next;
        end
        if (iLast) begin
          oDone   <= 1'b1;
          r_state <= S_IDLE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fixed_encoder_lpc.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_fixed_encoder_lpc: randomized bench with finite-difference model    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_fixed_encoder_lpc;

  localparam int DATA_W = 16;
  localparam int RES_W  = DATA_W + 4;
  localparam int SUM_W  = 32;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     start = 1'b0;
  logic [2:0]               order = 3'd0;
  logic                     enable = 1'b0;
  logic signed [DATA_W-1:0] sample = '0;
  logic                     last = 1'b0;
  logic signed [RES_W-1:0]  data;
  logic                     valid;
  logic                     warmup;
  logic [SUM_W-1:0]         abs_sum;
  logic                     done;
  logic                     order_err;

  always #5 clk = ~clk;

  fixed_encoder_lpc #(.DATA_W(DATA_W), .RES_W(RES_W), .SUM_W(SUM_W)) dut (
    .iClk(clk), .iRst(rst), .iStart(start), .iOrder(order), .iEnable(enable),
    .iSample(sample), .iLast(last), .oData(data), .oValid(valid), .oWarmup(warmup),
    .oAbsSum(abs_sum), .oDone(done), .oOrderErr(order_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: residual of sample k is the order-th backward difference of the block.
  int     m_blk[$];
  int     m_ord    = 0;
  bit     m_err    = 0;
  bit     m_active = 0;
  longint m_sum    = 0;

  longint n_data = 0, e_data = 0;
  bit     n_valid = 0, e_valid = 0;
  bit     n_warm = 0, e_warm = 0;
  bit     n_done = 0, e_done = 0;
  bit     n_err = 0, e_err = 0;
  longint n_sum = 0, e_sum = 0;
  bit     chk_en = 0;

  longint got_d[$];
  bit     got_w[$];

  function automatic longint binom(input int n, input int k);
    longint c = 1;
    for (int i = 0; i < k; i++) c = c * (n - i) / (i + 1);
    return c;
  endfunction

  function automatic longint backward_diff(input int ord);
    longint r = 0;
    int k = m_blk.size() - 1;
    for (int j = 0; j <= ord; j++)
      r += ((j % 2) ? -1 : 1) * binom(ord, j) * longint'(m_blk[k - j]);
    return r;
  endfunction

  always @(posedge clk) begin
    e_data  <= n_data;  e_valid <= n_valid; e_warm <= n_warm;
    e_done  <= n_done;  e_err   <= n_err;   e_sum  <= n_sum;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", valid, e_valid);
      chk("done", done, e_done);
      chk("abs_sum", abs_sum, e_sum);
      chk("order_err", order_err, e_err);
      chk("data", data, e_data);
      if (e_valid) chk("warmup", warmup, e_warm);
      if (valid) begin
        got_d.push_back(longint'(data));
        got_w.push_back(warmup);
      end
    end
  end

  task automatic drive(input bit st, input int ord, input bit en, input int smp,
                       input bit lst, input bit rs = 1'b0);
    longint r;
    @(negedge clk);
    rst = rs; start = st; order = 3'(ord); enable = en;
    sample = DATA_W'(smp); last = lst;
    n_valid = 0; n_done = 0;
    if (rs) begin
      m_active = 0; m_blk.delete(); m_sum = 0; m_err = 0; m_ord = 0;
      n_data = 0; n_warm = 0; n_err = 0; n_sum = 0;
      return;
    end
    if (st) begin
      m_err = (ord > 4); m_ord = m_err ? 0 : ord;
      m_blk.delete(); m_sum = 0; m_active = 1;
    end
    if (en && m_active) begin
      m_blk.push_back(int'(sample));
      if (m_blk.size() <= m_ord) begin
        n_data = int'(sample); n_warm = 1;
      end else begin
        r = backward_diff(m_ord);
        n_data = r; n_warm = 0;
        m_sum += (r < 0) ? -r : r;
        if (m_sum > 64'hFFFF_FFFF) m_sum = 64'hFFFF_FFFF;
      end
      n_valid = 1;
      if (lst) begin n_done = 1; m_active = 0; end
    end
    n_sum = m_sum; n_err = m_err;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic run_block(input int ord, input int s[$], input int gap, input bit with_last);
    got_d.delete(); got_w.delete();
    drive(1, ord, 0, 0, 0);
    for (int i = 0; i < s.size(); i++) begin
      drive(0, 0, 1, s[i], with_last && (i == s.size() - 1));
      if (i != s.size() - 1) idle(gap);
    end
    idle(2);
  endtask

  task automatic pin(input string nm, input longint exp[$]);
    chk({nm, "_count"}, got_d.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_d.size(); i++)
      chk(nm, got_d[i], exp[i]);
  endtask

  int rnd_s[$];

  function automatic int rand_sample();
    logic signed [DATA_W-1:0] t;
    case ($urandom_range(0, 7))
      0: return 32767;
      1: return -32768;
      default: begin t = DATA_W'($urandom); return int'(t); end
    endcase
  endfunction

  initial begin
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    chk_en = 1;
    idle(1);
    chk("reset_valid", valid, 0);
    chk("reset_sum", abs_sum, 0);

    run_block(3, '{20, 10, -7, -4, 8}, 0, 1);
    pin("ord3", '{20, 10, -7, 27, -11});
    chk("ord3_sum", abs_sum, 38);
    chk("ord3_warm2", got_w[2], 1);
    chk("ord3_warm3", got_w[3], 0);

    run_block(1, '{10, -7, -4}, 0, 1);
    pin("ord1", '{10, -17, 3});
    run_block(2, '{10, -7, -4, 8}, 0, 1);
    pin("ord2", '{10, -7, 20, 9});
    chk("ord2_sum", abs_sum, 29);
    run_block(0, '{10, -7}, 0, 1);
    pin("ord0", '{10, -7});
    chk("ord0_warm", got_w[0], 0);

    run_block(4, '{32767, -32768, 32767, -32768, 32767}, 0, 1);
    chk("ord4_pos", got_d[4], 524280);
    run_block(4, '{-32768, 32767, -32768, 32767, -32768}, 0, 1);
    chk("ord4_neg", got_d[4], -524280);

    run_block(2, '{5, 6, 7}, 3, 1);
    pin("gap", '{5, 6, 0});

    run_block(6, '{3, -4}, 0, 1);
    pin("order_err", '{3, -4});
    chk("order_err_flag", order_err, 1);

    run_block(3, '{1, 2}, 0, 1);
    chk("short_sum", abs_sum, 0);

    // Restart mid-RUN with a sample on the start cycle.
    run_block(1, '{10, -7, 4}, 0, 0);
    got_d.delete(); got_w.delete();
    drive(1, 1, 1, 5, 0);
    idle(2);
    chk("restart_warm", got_w[0], 1);
    chk("restart_data", got_d[0], 5);
    chk("restart_sum", abs_sum, 0);

    run_block(2, '{1, 2, 3}, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    idle(1);
    chk("midrst_sum", abs_sum, 0);

    for (int b = 0; b < 150; b++) begin
      int ord = $urandom_range(0, 7);
      int len = $urandom_range(1, 9);
      int abort = $urandom_range(0, 9);
      bit first_on_start = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) drive(0, 0, 1, rand_sample(), 1);
      drive(1, ord, first_on_start, rand_sample(), first_on_start && len == 1);
      for (int i = first_on_start ? 1 : 0; i < len; i++) begin
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        drive(0, 0, 1, rand_sample(), (i == len - 1) && abort > 1);
      end
      if (abort == 0) drive(0, 0, 0, 0, 0, 1);
      idle($urandom_range(0, 2));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
